// File: rtl/proc_host_mem.sv
// rtl/proc_host_mem.sv - host-side line memory responder for proc's memory-arbiter IO port
// Four 512-line regions of 512-bit lines, read/write/cv-report handshake plus a host preload port.
module proc_host_mem #(
  parameter int LINES  = 512,
  parameter int RD_LAT = 10,
  parameter int WR_LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   op,
  input  logic [31:0]  io_addr,
  input  logic [511:0] common_data_bus_out,
  input  logic [63:0]  cv_value,
  output logic [511:0] common_data_bus_in,
  output logic         tx_done,
  output logic         rd_valid,
  output logic [63:0]  cv_status,
  output logic         cv_valid,
  output logic         err_addr,
  input  logic         host_we,
  input  logic [10:0]  host_line,
  input  logic [511:0] host_wdata,
  output logic [511:0] host_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_WAIT, S_RD_DONE, S_RD_VALID, S_WR_WAIT, S_WR_DONE, S_CV_DONE, S_GAP
  } state_t;

  localparam int CW    = 8;
  localparam int DEPTH = 4 * LINES;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [10:0]     idx_q, idx_d;
  logic            bad_q, bad_d;
  logic            err_q, err_d;
  logic [63:0]     cvs_q, cvs_d;
  logic            cvv_q, cvv_d;
  logic [511:0]    bus_q;
  logic [511:0]    hr_q;
  logic            rd_fetch;
  logic            wr_commit;
  logic            addr_bad;
  logic            unused_lo;
  logic [511:0]    mem_q [DEPTH];

  assign addr_bad  = (io_addr[31:30] != 2'b00) || (io_addr[27:15] != 13'd0);
  assign unused_lo = ^io_addr[5:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    bad_d     = bad_q;
    err_d     = err_q;
    cvs_d     = cvs_q;
    cvv_d     = 1'b0;
    tx_done   = 1'b0;
    rd_valid  = 1'b0;
    rd_fetch  = 1'b0;
    wr_commit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (op == 2'b10) begin
          state_d = S_CV_DONE;
        end else if (op != 2'b00) begin
          idx_d = {io_addr[29:28], io_addr[14:6]};
          bad_d = addr_bad;
          err_d = err_q | addr_bad;
          if (op == 2'b01) begin
            state_d = S_RD_WAIT;
            cnt_d   = CW'(RD_LAT - 1);
          end else begin
            state_d = S_WR_WAIT;
            cnt_d   = CW'(WR_LAT - 1);
          end
        end
      end
      S_RD_WAIT: begin
        // Line is sampled at the edge leaving the last wait cycle.
        if (cnt_q == '0) begin
          rd_fetch = 1'b1;
          state_d  = S_RD_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RD_DONE: begin
        tx_done = 1'b1;
        state_d = S_RD_VALID;
      end
      S_RD_VALID: begin
        rd_valid = 1'b1;
        state_d  = S_GAP;
      end
      S_WR_WAIT: begin
        if (cnt_q == '0) state_d = S_WR_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_WR_DONE: begin
        tx_done   = 1'b1;
        wr_commit = ~bad_q;
        state_d   = S_GAP;
      end
      S_CV_DONE: begin
        tx_done = 1'b1;
        cvs_d   = cv_value;
        cvv_d   = 1'b1;
        state_d = S_GAP;
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      bad_q   <= 1'b0;
      err_q   <= 1'b0;
      cvs_q   <= '0;
      cvv_q   <= 1'b0;
      bus_q   <= '0;
      hr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
      cvs_q   <= cvs_d;
      cvv_q   <= cvv_d;
      hr_q    <= mem_q[host_line];
      if (rd_fetch) bus_q <= bad_q ? '0 : mem_q[idx_q];
    end
  end

  // Processor commit is written last so it wins a same-line collision with the host.
  always_ff @(posedge clk) begin
    if (host_we)            mem_q[host_line] <= host_wdata;
    if (rst_n && wr_commit) mem_q[idx_q]     <= common_data_bus_out;
  end

  assign common_data_bus_in = bus_q;
  assign cv_status          = cvs_q;
  assign cv_valid           = cvv_q;
  assign err_addr           = err_q;
  assign host_rdata         = hr_q;

endmodule

// File: tb/tb_proc_host_mem.sv
// tb/tb_proc_host_mem.sv - self-checking bench for proc_host_mem
// Event-schedule reference model compared every cycle, plus directed literal checks.
module tb_proc_host_mem;
  localparam int RD_LAT = 10;
  localparam int WR_LAT = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [31:0]  io_addr = '0;
  logic [511:0] bus_out = '0;
  logic [63:0]  cv_value = '0;
  logic [511:0] bus_in;
  logic         tx_done, rd_valid, cv_valid, err_addr;
  logic [63:0]  cv_status;
  logic         host_we = 1'b0;
  logic [10:0]  host_line = '0;
  logic [511:0] host_wdata = '0;
  logic [511:0] host_rdata;

  always #5 clk = ~clk;

  proc_host_mem #(.LINES(512), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .io_addr(io_addr),
    .common_data_bus_out(bus_out), .cv_value(cv_value),
    .common_data_bus_in(bus_in), .tx_done(tx_done), .rd_valid(rd_valid),
    .cv_status(cv_status), .cv_valid(cv_valid), .err_addr(err_addr),
    .host_we(host_we), .host_line(host_line), .host_wdata(host_wdata),
    .host_rdata(host_rdata)
  );

  int total = 0;
  int bad   = 0;

  function automatic logic [511:0] pat(input int i);
    return {16{32'h1000_0000 | 32'(i)}};
  endfunction

  task automatic chkw(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Reference model: each accepted op becomes a set of absolute edge numbers.
  int           cyc = 0;
  logic [511:0] mm [2048];
  bit           mk [2048];
  logic [511:0] e_bus = '0, e_hr = '0;
  bit           e_hr_ok = 1'b1;
  logic         e_err = 1'b0;
  logic [63:0]  e_cvs = '0;
  int           next_acc = 0, tx_at = -1, rv_at = -1, cvv_at = -1;
  int           fetch_at = -1, wr_at = -1, cv_at = -1;
  logic [10:0]  m_idx = '0;
  bit           m_bad = 1'b0;

  always @(posedge clk) begin
    logic [511:0] hr_now;
    bit           hr_ok;
    cyc++;
    if (!rst_n) begin
      e_bus = '0; e_hr = '0; e_hr_ok = 1'b1; e_err = 1'b0; e_cvs = '0;
      next_acc = 0; tx_at = -1; rv_at = -1; cvv_at = -1;
      fetch_at = -1; wr_at = -1; cv_at = -1;
    end else begin
      if (cyc == fetch_at) e_bus = m_bad ? '0 : mm[m_idx];
      if (cyc == cv_at) e_cvs = cv_value;
      hr_now = mm[host_line];
      hr_ok  = mk[host_line];
      if (cyc >= next_acc && op != 2'b00) begin
        if (op == 2'b10) begin
          tx_at = cyc; cvv_at = cyc + 1; cv_at = cyc + 1; next_acc = cyc + 3;
        end else begin
          m_idx = {io_addr[29:28], io_addr[14:6]};
          m_bad = (io_addr[31:30] != 0) || (io_addr[27:15] != 0);
          if (m_bad) e_err = 1'b1;
          if (op == 2'b01) begin
            tx_at = cyc + RD_LAT; rv_at = cyc + RD_LAT + 1;
            fetch_at = cyc + RD_LAT; next_acc = cyc + RD_LAT + 4;
          end else begin
            tx_at = cyc + WR_LAT; wr_at = cyc + WR_LAT + 1; next_acc = cyc + WR_LAT + 3;
          end
        end
      end
      if (host_we) begin
        mm[host_line] = host_wdata;
        mk[host_line] = 1'b1;
      end
      if (cyc == wr_at && !m_bad) begin
        mm[m_idx] = bus_out;
        mk[m_idx] = 1'b1;
      end
      e_hr = hr_now;
      e_hr_ok = hr_ok;
    end
  end

  always @(posedge clk) begin
    #2;
    chkb("m_tx_done", tx_done, cyc == tx_at);
    chkb("m_rd_valid", rd_valid, cyc == rv_at);
    chkb("m_cv_valid", cv_valid, cyc == cvv_at);
    chkb("m_err_addr", err_addr, e_err);
    chkw("m_bus_in", bus_in, e_bus);
    chkw("m_cv_status", {448'b0, cv_status}, {448'b0, e_cvs});
    if (e_hr_ok) chkw("m_host_rdata", host_rdata, e_hr);
  end

  task automatic wait_tx(input string nm, output int t);
    t = -1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #2;
      if (tx_done) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      total++; bad++;
      $display("FAIL %s: tx_done got none want pulse within 40 cycles", nm);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, t, t1, t2, n;
    repeat (3) @(negedge clk);
    chkb("rst_tx", tx_done, 1'b0);
    chkb("rst_err", err_addr, 1'b0);
    chkw("rst_bus", bus_in, '0);
    rst_n = 1'b1;

    for (int i = 0; i < 2048; i++) begin
      host_we = 1'b1; host_line = 11'(i); host_wdata = pat(i);
      @(negedge clk);
    end
    host_we = 1'b0;
    repeat (2) @(negedge clk);

    // single read of region 0 line 1
    op = 2'b01; io_addr = 32'h0000_0040; e = cyc + 1;
    wait_tx("rd1", t);
    chki("rd1_lat", t - e, RD_LAT);
    chkw("rd1_data", bus_in, {16{32'h1000_0001}});
    @(negedge clk); op = 2'b00;
    @(posedge clk); #2;
    chkb("rd1_rv", rd_valid, 1'b1);
    chkb("rd1_tx_low", tx_done, 1'b0);
    @(posedge clk); #2;
    chkb("rd1_gap_rv", rd_valid, 1'b0);
    chkw("rd1_hold", bus_in, {16{32'h1000_0001}});
    repeat (3) @(negedge clk);

    // write to shared region line 0
    op = 2'b11; io_addr = 32'h3000_0000; bus_out = {16{32'h3002}}; e = cyc + 1;
    wait_tx("wr1", t);
    chki("wr1_lat", t - e, WR_LAT);
    @(negedge clk); op = 2'b00;
    repeat (4) @(negedge clk);
    host_line = 11'h600;
    @(posedge clk); #2;
    chkw("wr1_host_rd", host_rdata, {16{32'h3002}});
    chkb("wr1_err", err_addr, 1'b0);
    repeat (2) @(negedge clk);

    // op held: one transaction per GAP, second accepted 14 edges later
    op = 2'b01; io_addr = 32'h0000_0080; e = cyc + 1; n = 0; t1 = -1; t2 = -1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #2;
      if (tx_done) begin
        n++;
        if (t1 < 0) t1 = cyc; else t2 = cyc;
      end
    end
    @(negedge clk); op = 2'b00;
    chki("hold_count", n, 2);
    chki("hold_first", t1 - e, RD_LAT);
    chki("hold_spacing", t2 - t1, RD_LAT + 4);
    repeat (20) @(negedge clk);

    // out-of-range read then dropped out-of-range write
    op = 2'b01; io_addr = 32'h4000_0000; e = cyc + 1;
    wait_tx("bad_rd", t);
    chki("bad_rd_lat", t - e, RD_LAT);
    chkw("bad_rd_data", bus_in, '0);
    chkb("bad_rd_err", err_addr, 1'b1);
    @(negedge clk); op = 2'b00;
    repeat (4) @(negedge clk);
    op = 2'b11; io_addr = 32'h1000_8000; bus_out = {512{1'b1}};
    wait_tx("bad_wr", t);
    @(negedge clk); op = 2'b00;
    repeat (6) @(negedge clk);
    host_line = 11'h200;
    @(posedge clk); #2;
    chkw("bad_wr_dropped", host_rdata, {16{32'h1000_0200}});
    repeat (2) @(negedge clk);

    // cv report
    op = 2'b10; cv_value = 64'hDEAD_BEEF_0000_0001; e = cyc + 1;
    wait_tx("cv", t);
    chki("cv_lat", t - e, 0);
    @(negedge clk); op = 2'b00;
    @(posedge clk); #2;
    chkb("cv_valid_pulse", cv_valid, 1'b1);
    chkw("cv_status_val", {448'b0, cv_status}, {448'b0, 64'hDEAD_BEEF_0000_0001});
    @(posedge clk); #2;
    chkb("cv_valid_end", cv_valid, 1'b0);
    repeat (3) @(negedge clk);

    // back-to-back reads then writes over region 1 lines 0..127
    op = 2'b01;
    for (int j = 0; j < 128; j++) begin
      io_addr = 32'h1000_0000 + 32'(64 * j);
      wait_tx("bb_rd", t);
      if (j == 5) chkw("bb_rd5", bus_in, {16{32'h1000_0205}});
      @(negedge clk);
    end
    op = 2'b11;
    for (int j = 0; j < 128; j++) begin
      io_addr = 32'h1000_0000 + 32'(64 * j);
      bus_out = {16{32'hA500_0000 | 32'(j)}};
      wait_tx("bb_wr", t);
      @(negedge clk);
      @(negedge clk);
    end
    op = 2'b00;
    repeat (4) @(negedge clk);
    for (int j = 0; j < 128; j++) begin
      @(negedge clk); host_line = 11'h200 + 11'(j);
      @(posedge clk); #2;
      chkw("roundtrip", host_rdata, {16{32'hA500_0000 | 32'(j)}});
    end

    // reset during RD_WAIT
    @(negedge clk); op = 2'b01; io_addr = 32'h0000_0000;
    @(negedge clk); op = 2'b00;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chkb("rst_mid_tx", tx_done, 1'b0);
    chkb("rst_mid_rv", rd_valid, 1'b0);
    chkb("rst_mid_cvv", cv_valid, 1'b0);
    chkb("rst_mid_err", err_addr, 1'b0);
    chkw("rst_mid_bus", bus_in, '0);
    chkw("rst_mid_cvs", {448'b0, cv_status}, '0);
    chkw("rst_mid_hr", host_rdata, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #2;
      if (tx_done || rd_valid) n++;
    end
    chki("rst_no_strobe", n, 0);

    // recovery read of region 0 line 0
    @(negedge clk); op = 2'b01; io_addr = 32'h0000_0000; e = cyc + 1;
    wait_tx("post_rst_rd", t);
    chki("post_rst_lat", t - e, RD_LAT);
    chkw("post_rst_data", bus_in, {16{32'h1000_0000}});
    @(negedge clk); op = 2'b00;
    repeat (6) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/proc_host_mem.md
# proc_host_mem

Host-side memory responder that sits directly downstream of `proc` on its IO interface and services the processor's memory-arbiter requests. It decodes `op` and `io_addr`, supplies 512-bit cache lines from a banked line memory on reads, and absorbs 512-bit lines on writes, using the `tx_done`/`rd_valid` handshake. It also latches the processor's 64-bit `cv_value` status reports. A side-band host port preloads and inspects memory, for example instruction images and FFT input/output.

## Interface
- `LINES`, 512: lines per region; 64 B each, 32 KB per region.
- `RD_LAT`, 10: cycles from read acceptance to `tx_done`; must be ≥1.
- `WR_LAT`, 2: cycles from write acceptance to `tx_done`; must be ≥1.
- `clk`  in  1  clock; everything is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `op`  in  2  from proc: 00 idle, 01 line read, 11 line write, 10 cv report.
- `io_addr`  in  32  byte address from proc.
- `common_data_bus_out`  in  512  write line from proc.
- `cv_value`  in  64  status word from proc.
- `common_data_bus_in`  out  512  read line to proc.
- `tx_done`  out  1  transfer-complete strobe.
- `rd_valid`  out  1  read-data-valid strobe, one cycle after `tx_done` on reads.
- `cv_status`  out  64  last latched `cv_value`.
- `cv_valid`  out  1  one-cycle pulse when `cv_status` updates.
- `err_addr`  out  1  sticky out-of-range flag.
- `host_we`  in  1  host line write.
- `host_line`  in  11  host line index, as {region[1:0], line[8:0]}.
- `host_wdata`  in  512  host write data.
- `host_rdata`  out  512  registered read of `host_line`, 1-cycle latency.

## Operation
- **Address decode**
  - Region = `io_addr[29:28]`; regions are 0 instr, 1 accel, 2 data, 3 shared.
  - Line = `io_addr[14:6]`; `io_addr[5:0]` is ignored.
  - The address is out of range if `io_addr[31:30]` != 0 or `io_addr[27:15]` != 0.
  - On out of range: set `err_addr`, return all-zero data on reads, drop writes. The handshake still completes.
- **States**: IDLE, RD_WAIT, RD_DONE, RD_VALID, WR_WAIT, WR_DONE, CV_DONE, GAP.
- **IDLE**: samples `op` every cycle.
  - 01 → RD_WAIT with counter = `RD_LAT`-1.
  - 11 → WR_WAIT with counter = `WR_LAT`-1.
  - 10 → CV_DONE.
  - 00 → stay in IDLE.
  - `io_addr` is captured on acceptance; later changes to it are ignored.
- **RD_WAIT**: decrement the counter; at 0 → RD_DONE. The line is fetched during this state.
- **RD_DONE**: `tx_done`=1, `common_data_bus_in` = fetched line → RD_VALID.
- **RD_VALID**: `rd_valid`=1; `common_data_bus_in` holds its value → GAP.
- **WR_WAIT**: counts like RD_WAIT → WR_DONE.
- **WR_DONE**: `tx_done`=1.
  - The memory line is written with `common_data_bus_out` as sampled on the edge leaving WR_DONE.
  - → GAP.
- **CV_DONE**: `tx_done`=1.
  - `cv_status` ← `cv_value` on the edge leaving CV_DONE; `cv_valid` pulses in the following cycle.
  - → GAP.
- **GAP**: one cycle with `op` ignored, so a still-held `op` cannot retrigger → IDLE.
- **Host port**: active in every state.
  - If a host write and a WR_DONE commit hit the same line on the same edge, the processor write wins.
  - A host write to the line being fetched during RD_WAIT is visible only if it lands before the final RD_WAIT cycle.

## Timing
- **Reset values**: all outputs 0, state IDLE, memory contents undefined.
- **Reset mid-transaction**: immediate return to IDLE with strobes low; any pending write is discarded.
- **Read latency**:
  - `op`=01 sampled at edge E.
  - `tx_done` is high in cycle E+`RD_LAT`+1; `rd_valid` is high in cycle E+`RD_LAT`+2.
  - The earliest next acceptance is at edge E+`RD_LAT`+4.
- **Write latency**: `tx_done` is high in cycle E+`WR_LAT`+1; the memory commit happens at the end of that cycle.
- **Strobe widths**:
  - `tx_done`, `rd_valid` and `cv_valid` are exactly one cycle wide.
  - `tx_done` and `rd_valid` are never high together.
- **`err_addr`**: set on the acceptance edge; cleared only by reset.
- **`common_data_bus_in`**: holds the last read line until the next RD_DONE.

## Test plan
- Preload region 0 lines 0–1 via the host port; `op`=01, `io_addr`=0x0000_0040 → after 10 wait cycles, `tx_done` for 1 cycle with line 1 data, then `rd_valid` for 1 cycle, then GAP, then IDLE.
- `op`=11, `io_addr`=0x3000_0000, bus_out = 16×32'h3002 → `tx_done` at E+3; host read of line {3,0} = 16×32'h3002; `err_addr`=0.
- Hold `op`=01 through completion → exactly one transaction until GAP ends, then a second one accepted at E+14.
- `op`=01 at 0x4000_0000 → `err_addr`=1, `common_data_bus_in`=0, handshake timing unchanged; a subsequent write to 0x1000_8000 leaves memory unchanged.
- `op`=10, `cv_value`=64'hDEAD_BEEF_0000_0001 → `tx_done`=1 for one cycle, then `cv_valid` pulse, `cv_status` matches.
- 128 back-to-back reads at 0x1000_0000 + 64·j, then 128 writes to the same addresses → data round-trips; assert `rst_n` low during RD_WAIT and confirm all outputs are 0 and no strobe occurs.
